// File: rtl/fetch_unit.sv
// Fetch PC generation, in-order imem requests, fetch queue to decode.
// Optional FETCH_REDIRECT_BYPASS_EN issues the redirect PC in the redirect cycle.
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] bpPc,
  input  logic        bpHit,
  input  logic [31:0] bpTarget,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        deqValid,
  input  logic        deqReady,
  output logic [31:0] deqInstr,
  output logic [31:0] deqPc,
  output logic        deqPredTaken,
  output logic [31:0] deqPredTarget
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predTarget;
    logic [31:0] instr;
    logic        filled;
  } slot_t;

  slot_t         slots [QUEUE_DEPTH];
  slot_t         headSlot;
  slot_t         newSlot;
  logic [PW-1:0] allocPtr;
  logic [PW-1:0] fillPtr;
  logic [PW-1:0] headPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] inFlight;
  logic [CW-1:0] dropCount;
  logic [31:0]   pc;
  logic [31:0]   reqPc;
  logic [31:0]   nextPc;
  logic          bypass;
  logic          grant;
  logic          fill;
  logic          drop;
  logic          deq;

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_REDIRECT_BYPASS_EN
    bypass = rst && redirectValid
          && dropCount == '0 && inFlight == '0;
`endif
    reqPc   = bypass ? redirectPc : pc;
    imemReq = bypass
           || (rst && !redirectValid
               && dropCount == '0
               && count < CW'(QUEUE_DEPTH));
    imemAddr = reqPc;
    bpPc     = reqPc;
    grant    = imemReq && imemGnt;
    nextPc   = bpHit ? bpTarget : reqPc + 32'd4;
    newSlot  = '{pc: reqPc,
                 predTaken: bpHit,
                 predTarget: bpHit ? bpTarget : 32'd0,
                 instr: 32'd0,
                 filled: 1'b0};
    fill     = imemRvalid && dropCount == '0;
    drop     = imemRvalid && dropCount != '0;
    headSlot = slots[headPtr];
    deqValid = rst && !redirectValid
            && count != '0 && headSlot.filled;
    deq           = deqValid && deqReady;
    deqInstr      = headSlot.instr;
    deqPc         = headSlot.pc;
    deqPredTaken  = deqValid && headSlot.predTaken;
    deqPredTarget = headSlot.predTarget;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      allocPtr  <= '0;
      fillPtr   <= '0;
      headPtr   <= '0;
      count     <= '0;
      inFlight  <= '0;
      dropCount <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        slots[i] <= '0;
    end else if (redirectValid) begin
      allocPtr  <= '0;
      fillPtr   <= '0;
      headPtr   <= '0;
      count     <= '0;
      inFlight  <= '0;
      // stale responses still owed by memory get swallowed
      dropCount <= dropCount + inFlight
                 - CW'(imemRvalid);
      pc        <= redirectPc;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        slots[i].filled <= 1'b0;
      if (grant) begin
        slots[0] <= newSlot;
        allocPtr <= PW'(1);
        count    <= CW'(1);
        inFlight <= CW'(1);
        pc       <= nextPc;
      end
    end else begin
      if (grant) begin
        slots[allocPtr] <= newSlot;
        allocPtr        <= allocPtr + PW'(1);
        pc              <= nextPc;
      end
      if (drop)
        dropCount <= dropCount - CW'(1);
      if (fill) begin
        slots[fillPtr].instr  <= imemRdata;
        slots[fillPtr].filled <= 1'b1;
        fillPtr               <= fillPtr + PW'(1);
      end
      if (deq) begin
        slots[headPtr].filled <= 1'b0;
        headPtr               <= headPtr + PW'(1);
      end
      count    <= count + CW'(grant) - CW'(deq);
      inFlight <= inFlight + CW'(grant) - CW'(fill);
    end
  end

  always @(posedge clk) begin
    if (rst && imemRvalid)
      assert (dropCount != '0 || inFlight != '0);
  end

endmodule
